sample_playback_buffer: RTL
===========================

# sample_playback_buffer

Downstream consumer of the DMA receiver's mixed-sample output. Pulls mixed stereo words (right in [31:16], left in [15:0]) whenever the receiver offers them. Stores them in a circular buffer and delivers exactly one word per codec sample request. Handles prefill, underrun (silence plus counting) and flush on stop, so the codec sees a steady stream at the audio rate.

## Interface
- `DEPTH`, 256, buffer depth in 32-bit words; power of two, ≥ 4.
- `PREFILL_LEVEL`, 64, fill level required before playback starts or restarts; 1..DEPTH.
- `LOW_WATERMARK`, 32, `buffer_low` asserts while fill level is below this value.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `stop`  in  1  flush buffer and return to IDLE while high.
- `sample_data`  in  32  mixed word from the receiver; valid while `sample_data_available` is high.
- `sample_data_available`  in  1  receiver has a word at `sample_data`.
- `sample_data_read`  out  1  pop strobe to the receiver.
- `playback_sample_req`  in  1  one-cycle strobe from the codec interface requesting the next word.
- `playback_sample_data`  out  32  word answering the request.
- `playback_sample_valid`  out  1  one-cycle pulse qualifying `playback_sample_data`.
- `fill_level`  out  $clog2(DEPTH)+1  number of stored words.
- `buffer_low`  out  1  `fill_level < LOW_WATERMARK`.
- `underrun_count`  out  16  saturating count of requests that hit an empty buffer in PLAY.

## Operation
- **States:**
  - IDLE → PREFILL when `stop` = 0.
  - PREFILL → PLAY when `fill_level >= PREFILL_LEVEL`.
  - PLAY → PREFILL on an underrun.
  - Any state → IDLE when `stop` = 1. Priority is `reset` > `stop` > other transitions.
- **Ingress:**
  - `sample_data_read = sample_data_available & ~full & ~stop & ~reset`, combinational.
  - A word is written at `wr_ptr` in every cycle where `sample_data_read` = 1.
  - Ingress is active in IDLE (when `stop` = 0), PREFILL and PLAY.
- **Egress in PLAY, request with buffer non-empty:** read at `rd_ptr` and increment `rd_ptr`.
- **Egress in PLAY, request with buffer empty:**
  - Return 0x0000_0000.
  - Increment `underrun_count`, saturating at 0xFFFF.
  - Go to PREFILL.
- **Egress in IDLE or PREFILL:** return 0x0000_0000. No pop, no underrun count.
- **Full and empty:**
  - Pointers are $clog2(DEPTH)+1 bits.
  - Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - Pointers wrap naturally.
  - `fill_level = wr_ptr - rd_ptr`, modulo 2^(width).
- **Simultaneous push and pop:** both happen; `fill_level` is unchanged. A push into an empty buffer does not satisfy a request in the same cycle; that request is an underrun.
- **Stop:**
  - Pointers clear at the next edge and `fill_level` reads 0.
  - A request pending in that cycle is answered with zero.
  - `underrun_count` is retained; only `reset` clears it.
- **Data:** words pass through unmodified. No saturation or scaling; the mixer owns the arithmetic.

## Timing
- **Reset values:**
  - `playback_sample_data` = 0, `playback_sample_valid` = 0.
  - `fill_level` = 0, `underrun_count` = 0.
  - `buffer_low` = 1 when LOW_WATERMARK > 0.
  - `sample_data_read` = 0 while `reset` is high.
  - State = IDLE, pointers = 0.
- **Request latency:** exactly 1 cycle. A request at cycle N gives `playback_sample_valid` = 1 at N+1 with data registered. Every request yields exactly one valid pulse.
- **Back-to-back requests:** requests on consecutive cycles are legal and produce consecutive valid pulses.
- **Write-to-read:** a word written at cycle N is readable by a request at N+1 or later. The RAM read is synchronous, and the pointer comparison uses registered pointers.
- **Registered outputs:** `fill_level` and `buffer_low` are registered and reflect the pointers after each edge.
- **Prefill transition:** PREFILL → PLAY is evaluated on the registered `fill_level`. A request arriving in the same cycle as that transition is still answered as PREFILL, with zero.

## Structure
- **Package `sampler_playback_pkg`:**
  - State enum `playback_state_t` {IDLE, PREFILL, PLAY}.
  - `SILENCE_WORD` = 32'h0.
  - Underrun counter width, 16.
- **Sub-module `sample_playback_ram`:**
  - Simple dual-port RAM, DEPTH × 32.
  - One write port, one synchronous read port, no reset on contents.
- Top level holds the pointers, FSM, counters and output register.

## Test plan
- **Prefill:** after reset, offer 64 words 0x0001_0001..0x0040_0040; issue 3 requests during prefill and 2 after PLAY.
  - Prefill requests return 0 with valid pulses.
  - Post-PLAY requests return 0x0001_0001 then 0x0002_0002, each one cycle after its request.
- **Full:** hold `sample_data_available` = 1 with no requests.
  - `sample_data_read` drops when `fill_level` = 256.
  - Issue one request: one word pops, `sample_data_read` pulses once, `fill_level` returns to 256.
- **Underrun:** PREFILL_LEVEL = 4, load 4 words, issue 5 requests.
  - The fifth request returns 0 and `underrun_count` = 1; state goes to PREFILL.
  - Further requests return 0 with no extra count.
- **Simultaneous push and pop:** at `fill_level` = 10, push and request in the same cycle.
  - `fill_level` stays 10; the returned word is the oldest stored word.
- **Stop mid-play:** with 100 words stored, assert `stop` together with a request.
  - The request returns 0; `fill_level` = 0 next cycle; `sample_data_read` = 0 while `stop` is high.
  - `underrun_count` is preserved.
  - After `stop` releases, refill to 64 before any data is returned.
- **Wrap:** stream 1000 incrementing words with a request every 4th cycle.
  - Output sequence is strictly incrementing with no loss; `underrun_count` = 0.

Source files
------------

// File: rtl/sample_playback_buffer_pkg.sv
// Shared types and constants for the sample playback buffer slice.
package sampler_playback_pkg;

  // Playback controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    PLAY    = 2'd2
  } playback_state_t;

  // Width of one mixed stereo word (right in [31:16], left in [15:0]).
  localparam int SAMPLE_W = 32;

  // Word returned whenever there is nothing real to play.
  localparam logic [SAMPLE_W-1:0] SILENCE_WORD = 32'h0000_0000;

  // Underrun counter width and its saturation value.
  localparam int UNDERRUN_W = 16;
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = 16'hFFFF;

  // Increment that sticks at the maximum instead of wrapping to zero.
  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] value);
    logic [UNDERRUN_W-1:0] result;
    if (value == UNDERRUN_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_playback_buffer_if.sv
// Receiver-side pop handshake and codec-side request/response bundled together.
interface sample_playback_buffer_if;
  import sampler_playback_pkg::*;

  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_data_available;
  logic                sample_data_read;
  logic                playback_sample_req;
  logic [SAMPLE_W-1:0] playback_sample_data;
  logic                playback_sample_valid;

  // Environment side: offers words and issues codec requests.
  modport master (
    output sample_data,
    output sample_data_available,
    input  sample_data_read,
    output playback_sample_req,
    input  playback_sample_data,
    input  playback_sample_valid
  );

  // Buffer side: pops the receiver and answers codec requests.
  modport slave (
    input  sample_data,
    input  sample_data_available,
    output sample_data_read,
    input  playback_sample_req,
    output playback_sample_data,
    output playback_sample_valid
  );

endinterface

// File: rtl/sample_playback_buffer_ram.sv
// Simple dual-port DEPTH x 32 storage with a registered read port.
// The read register doubles as the output register: it loads the addressed
// word on a pop and loads silence on any other answered request.
module sample_playback_ram
  import sampler_playback_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  input  logic                rd_clr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem_r [DEPTH];
  logic [SAMPLE_W-1:0] rd_data_r;

  // Store incoming words; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Synchronous read, or silence for a request that cannot be served.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data_r <= SILENCE_WORD;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sample_playback_buffer.sv
// Circular playback buffer between the DMA receiver and the codec.
// Prefills before playing, answers every codec request one cycle later,
// plays silence and counts underruns, and flushes while stop is high.
module sample_playback_buffer
  import sampler_playback_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int PREFILL_LEVEL = 64,
  parameter int LOW_WATERMARK = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stop,
  sample_playback_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]        fill_level,
  output logic                          buffer_low,
  output logic [UNDERRUN_W-1:0]         underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PREFILL_LVL  = PW'(PREFILL_LEVEL);
  localparam logic [PW-1:0] LOW_WM       = PW'(LOW_WATERMARK);
  localparam logic          LOW_AT_RESET = (LOW_WATERMARK > 0) ? 1'b1 : 1'b0;

  playback_state_t       state_r;
  playback_state_t       state_nx_s;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_nx_s;
  logic [PW-1:0]         rd_ptr_nx_s;
  logic [PW-1:0]         level_nx_s;
  logic [PW-1:0]         fill_level_r;
  logic                  buffer_low_r;
  logic [UNDERRUN_W-1:0] underrun_cnt_r;
  logic                  valid_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  underrun_s;
  logic                  rd_clr_s;

  // Extra pointer MSB distinguishes a full buffer from an empty one.
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);

  // Ingress runs in every state; only full, stop and reset hold it off.
  assign push_s               = bus.sample_data_available & ~full_s & ~stop & ~reset;
  assign bus.sample_data_read = push_s;

  // Classify the current request: real pop, underrun, or plain silence.
  always_comb begin
    pop_s      = 1'b0;
    underrun_s = 1'b0;
    if (bus.playback_sample_req && !stop && (state_r == PLAY)) begin
      if (empty_s) begin
        underrun_s = 1'b1;
      end else begin
        pop_s = 1'b1;
      end
    end else begin
      pop_s      = 1'b0;
      underrun_s = 1'b0;
    end
  end

  // Every request not served from storage must still return silence.
  assign rd_clr_s = reset | (bus.playback_sample_req & ~pop_s);

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    state_nx_s = state_r;
    if (stop) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = PREFILL;
        end
        PREFILL: begin
          if (fill_level_r >= PREFILL_LVL) begin
            state_nx_s = PLAY;
          end else begin
            state_nx_s = PREFILL;
          end
        end
        PLAY: begin
          if (underrun_s) begin
            state_nx_s = PREFILL;
          end else begin
            state_nx_s = PLAY;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // Pointer advance and flush; the level is taken from the next pointers.
  always_comb begin
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    if (stop) begin
      wr_ptr_nx_s = {PW{1'b0}};
      rd_ptr_nx_s = {PW{1'b0}};
    end else begin
      wr_ptr_nx_s = wr_ptr_r + PW'(push_s);
      rd_ptr_nx_s = rd_ptr_r + PW'(pop_s);
    end
    level_nx_s = wr_ptr_nx_s - rd_ptr_nx_s;
  end

  // Control state, pointers, status flags and the underrun counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      wr_ptr_r       <= {PW{1'b0}};
      rd_ptr_r       <= {PW{1'b0}};
      fill_level_r   <= {PW{1'b0}};
      buffer_low_r   <= LOW_AT_RESET;
      underrun_cnt_r <= {UNDERRUN_W{1'b0}};
      valid_r        <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      wr_ptr_r     <= wr_ptr_nx_s;
      rd_ptr_r     <= rd_ptr_nx_s;
      fill_level_r <= level_nx_s;
      buffer_low_r <= (level_nx_s < LOW_WM);
      valid_r      <= bus.playback_sample_req;
      if (underrun_s) begin
        underrun_cnt_r <= sat_inc(underrun_cnt_r);
      end
    end
  end

  sample_playback_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r[AW-1:0]),
    .wr_data (bus.sample_data),
    .rd_en   (pop_s),
    .rd_addr (rd_ptr_r[AW-1:0]),
    .rd_clr  (rd_clr_s),
    .rd_data (bus.playback_sample_data)
  );

  assign bus.playback_sample_valid = valid_r;
  assign fill_level                = fill_level_r;
  assign buffer_low                = buffer_low_r;
  assign underrun_count            = underrun_cnt_r;

endmodule
